// File: rtl/iob_cache_axi_write_engine.sv
// -----------------------------------------------------------------------------
// iob_cache_axi_write_engine
//
// Purpose: turns one front-end cache write request into a single AXI4 write
// transaction (AW + W beats + B). In write-through mode (WRITE_POL=0), one
// FE word goes out as a single beat with byte strobes steered into the
// right BE lane. In write-back mode (WRITE_POL=1), a whole cache line goes
// out as an INCR burst of NBEATS beats with full strobes.
//
// Configuration macro:
//   IOB_CACHE_AXI_WRITE_RETRY_EN - when defined, a non-OKAY write response
//   reissues the registered request up to MAX_RETRY times before it sets
//   error_o. When undefined, any non-OKAY response sets error_o at once.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   valid_i/ready_o         request handshake (ready_o only in IDLE)
//   addr_i, wdata_i, wstrb_i request byte address, word/line data, strobes
//   error_o, error_clr_i    sticky unrecoverable-error flag and its clear
//   axi_aw*                 AXI write address channel (master side)
//   axi_w*                  AXI write data channel (master side)
//   axi_b*                  AXI write response channel (master side)
// -----------------------------------------------------------------------------
module iob_cache_axi_write_engine #(
  parameter int ADDR_W        = 32,
  parameter int FE_DATA_W     = 32,
  parameter int BE_ADDR_W     = 32,
  parameter int BE_DATA_W     = 64,
  parameter int WORD_OFFSET_W = 2,
  parameter int WRITE_POL     = 0,
  parameter int AXI_ID_W      = 1,
  parameter int AXI_ID        = 0,
  parameter int AXI_LEN_W     = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  input  logic [ADDR_W-1:0]             addr_i,
  input  logic [((WRITE_POL != 0) ? (FE_DATA_W << WORD_OFFSET_W) : FE_DATA_W)-1:0] wdata_i,
  input  logic [FE_DATA_W/8-1:0]        wstrb_i,
  output logic                          ready_o,
  output logic                          error_o,
  input  logic                          error_clr_i,
  output logic [AXI_ID_W-1:0]           axi_awid_o,
  output logic [BE_ADDR_W-1:0]          axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]          axi_awlen_o,
  output logic [2:0]                    axi_awsize_o,
  output logic [1:0]                    axi_awburst_o,
  output logic                          axi_awlock_o,
  output logic [3:0]                    axi_awcache_o,
  output logic [2:0]                    axi_awprot_o,
  output logic [3:0]                    axi_awqos_o,
  output logic                          axi_awvalid_o,
  input  logic                          axi_awready_i,
  output logic [BE_DATA_W-1:0]          axi_wdata_o,
  output logic [BE_DATA_W/8-1:0]        axi_wstrb_o,
  output logic                          axi_wlast_o,
  output logic                          axi_wvalid_o,
  input  logic                          axi_wready_i,
  input  logic [AXI_ID_W-1:0]           axi_bid_i,
  input  logic [1:0]                    axi_bresp_i,
  input  logic                          axi_bvalid_i,
  output logic                          axi_bready_o
);

  localparam int LINE_W      = FE_DATA_W << WORD_OFFSET_W;
  localparam int WDATA_W     = (WRITE_POL != 0) ? LINE_W : FE_DATA_W;
  localparam int NBEATS      = (WRITE_POL != 0) ? LINE_W / BE_DATA_W : 1;
  localparam int BE_BYTES    = BE_DATA_W / 8;
  localparam int FE_BYTES    = FE_DATA_W / 8;
  localparam int ALIGN_BYTES = (WRITE_POL != 0) ? LINE_W / 8 : BE_BYTES;
  localparam int BEAT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [WDATA_W-1:0]    wdata_q, wdata_d;
  logic [FE_BYTES-1:0]   wstrb_q, wstrb_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  awDone_q, awDone_d;
  logic                  wDone_q, wDone_d;
  logic                  error_q, error_d;

  logic awHs;
  logic wHs;
  logic lastBeat;

`ifdef IOB_CACHE_AXI_WRITE_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retry_q, retry_d;
`else
  localparam int unusedMaxRetry = MAX_RETRY;
`endif

  logic unusedBid;
  assign unusedBid = ^axi_bid_i;

  // Each channel drops its valid after its own handshake, so AW and W run
  // independently inside XFER.
  assign axi_awvalid_o = (state_q == XFER) && !awDone_q;
  assign axi_wvalid_o  = (state_q == XFER) && !wDone_q;
  assign axi_bready_o  = (state_q == RESP);
  assign ready_o       = (state_q == IDLE);
  assign error_o       = error_q;

  assign awHs     = axi_awvalid_o && axi_awready_i;
  assign wHs      = axi_wvalid_o && axi_wready_i;
  assign lastBeat = (beat_q == BEAT_W'(NBEATS - 1));

  assign axi_wlast_o   = axi_wvalid_o && lastBeat;

  assign axi_awid_o    = AXI_ID_W'(AXI_ID);
  assign axi_awaddr_o  = BE_ADDR_W'(addr_q & ~ADDR_W'(ALIGN_BYTES - 1));
  assign axi_awlen_o   = AXI_LEN_W'(NBEATS - 1);
  assign axi_awsize_o  = 3'($clog2(BE_BYTES));
  assign axi_awburst_o = 2'b01;
  assign axi_awlock_o  = 1'b0;
  assign axi_awcache_o = 4'b0011;
  assign axi_awprot_o  = 3'b000;
  assign axi_awqos_o   = 4'b0000;

  generate
    if (WRITE_POL != 0) begin : g_wb
      // Line is sent lowest slice first; the beat counter picks the slice.
      logic unusedStrb;
      assign unusedStrb  = ^wstrb_q;
      assign axi_wdata_o = BE_DATA_W'(wdata_q >> (int'(beat_q) * BE_DATA_W));
      assign axi_wstrb_o = '1;
    end else begin : g_wt
      // The word is copied into every FE lane of the BE word; only the strobe
      // decides which lane the slave actually writes. The mask keeps the
      // FE-aligned byte offset of the word inside its BE word.
      localparam int RATIO = BE_DATA_W / FE_DATA_W;
      logic [ADDR_W-1:0] laneOffset;
      assign laneOffset  = addr_q & ADDR_W'(BE_BYTES - FE_BYTES);
      assign axi_wdata_o = {RATIO{wdata_q}};
      assign axi_wstrb_o = BE_BYTES'(wstrb_q) << laneOffset;
    end
  endgenerate

  // State and request registers; reset drops any in-flight request.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      beat_q   <= '0;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
      error_q  <= 1'b0;
`ifdef IOB_CACHE_AXI_WRITE_RETRY_EN
      retry_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      beat_q   <= beat_d;
      awDone_q <= awDone_d;
      wDone_q  <= wDone_d;
      error_q  <= error_d;
`ifdef IOB_CACHE_AXI_WRITE_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  // Next-state logic. The error set is evaluated after the clear so a
  // simultaneous set wins.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    beat_d   = beat_q;
    awDone_d = awDone_q;
    wDone_d  = wDone_q;
    error_d  = error_q;
`ifdef IOB_CACHE_AXI_WRITE_RETRY_EN
    retry_d  = retry_q;
`endif
    if (error_clr_i) error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          wstrb_d  = wstrb_i;
          beat_d   = '0;
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
`ifdef IOB_CACHE_AXI_WRITE_RETRY_EN
          retry_d  = '0;
`endif
          state_d  = XFER;
        end
      end
      XFER: begin
        if (awHs) awDone_d = 1'b1;
        if (wHs) begin
          if (lastBeat) begin
            beat_d  = '0;
            wDone_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
        if ((awDone_q || awHs) && (wDone_q || (wHs && lastBeat))) state_d = RESP;
      end
      RESP: begin
        if (axi_bvalid_i) begin
          if (axi_bresp_i == 2'b00) begin
            state_d = IDLE;
          end else begin
`ifdef IOB_CACHE_AXI_WRITE_RETRY_EN
            if (retry_q < RETRY_W'(MAX_RETRY)) begin
              retry_d  = retry_q + 1'b1;
              beat_d   = '0;
              awDone_d = 1'b0;
              wDone_d  = 1'b0;
              state_d  = XFER;
            end else begin
              error_d = 1'b1;
              state_d = IDLE;
            end
`else
            error_d = 1'b1;
            state_d = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_cache_axi_write_engine.sv
// -----------------------------------------------------------------------------
// tb_iob_cache_axi_write_engine
//
// Directed bench for iob_cache_axi_write_engine. Two instances share clock
// and reset: uWt is a write-through engine (FE 32 / BE 64) and uWb is a
// write-back engine (line 128 / BE 64). Both use MAX_RETRY = 2. The expected
// transfer count on an error response follows IOB_CACHE_AXI_WRITE_RETRY_EN.
// -----------------------------------------------------------------------------
module tb_iob_cache_axi_write_engine;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

`ifdef IOB_CACHE_AXI_WRITE_RETRY_EN
  localparam int EXP_XFERS = 3;
`else
  localparam int EXP_XFERS = 1;
`endif

  // Write-through instance signals
  logic        wtValid, wtReady, wtError, wtErrClr;
  logic [31:0] wtAddr, wtWdata;
  logic [3:0]  wtWstrb;
  logic [0:0]  wtAwid;
  logic [31:0] wtAwaddr;
  logic [7:0]  wtAwlen;
  logic [2:0]  wtAwsize, wtAwprot;
  logic [1:0]  wtAwburst, wtBresp;
  logic        wtAwlock, wtAwvalid, wtAwready;
  logic [3:0]  wtAwcache, wtAwqos;
  logic [63:0] wtWdataO;
  logic [7:0]  wtWstrbO;
  logic        wtWlast, wtWvalid, wtWready, wtBvalid, wtBready;

  // Write-back instance signals
  logic         wbValid, wbReady, wbError, wbErrClr;
  logic [31:0]  wbAddr;
  logic [127:0] wbWdata;
  logic [3:0]   wbWstrb;
  logic [0:0]   wbAwid;
  logic [31:0]  wbAwaddr;
  logic [7:0]   wbAwlen;
  logic [2:0]   wbAwsize, wbAwprot;
  logic [1:0]   wbAwburst, wbBresp;
  logic         wbAwlock, wbAwvalid, wbAwready;
  logic [3:0]   wbAwcache, wbAwqos;
  logic [63:0]  wbWdataO;
  logic [7:0]   wbWstrbO;
  logic         wbWlast, wbWvalid, wbWready, wbBvalid, wbBready;

  logic [0:0]   bid;

  always #5 clk = ~clk;

  iob_cache_axi_write_engine #(.WRITE_POL(0), .MAX_RETRY(2)) uWt (
    .clk_i(clk), .reset_i(reset), .valid_i(wtValid), .addr_i(wtAddr),
    .wdata_i(wtWdata), .wstrb_i(wtWstrb), .ready_o(wtReady), .error_o(wtError),
    .error_clr_i(wtErrClr), .axi_awid_o(wtAwid), .axi_awaddr_o(wtAwaddr),
    .axi_awlen_o(wtAwlen), .axi_awsize_o(wtAwsize), .axi_awburst_o(wtAwburst),
    .axi_awlock_o(wtAwlock), .axi_awcache_o(wtAwcache), .axi_awprot_o(wtAwprot),
    .axi_awqos_o(wtAwqos), .axi_awvalid_o(wtAwvalid), .axi_awready_i(wtAwready),
    .axi_wdata_o(wtWdataO), .axi_wstrb_o(wtWstrbO), .axi_wlast_o(wtWlast),
    .axi_wvalid_o(wtWvalid), .axi_wready_i(wtWready), .axi_bid_i(bid),
    .axi_bresp_i(wtBresp), .axi_bvalid_i(wtBvalid), .axi_bready_o(wtBready)
  );

  iob_cache_axi_write_engine #(.WRITE_POL(1), .MAX_RETRY(2)) uWb (
    .clk_i(clk), .reset_i(reset), .valid_i(wbValid), .addr_i(wbAddr),
    .wdata_i(wbWdata), .wstrb_i(wbWstrb), .ready_o(wbReady), .error_o(wbError),
    .error_clr_i(wbErrClr), .axi_awid_o(wbAwid), .axi_awaddr_o(wbAwaddr),
    .axi_awlen_o(wbAwlen), .axi_awsize_o(wbAwsize), .axi_awburst_o(wbAwburst),
    .axi_awlock_o(wbAwlock), .axi_awcache_o(wbAwcache), .axi_awprot_o(wbAwprot),
    .axi_awqos_o(wbAwqos), .axi_awvalid_o(wbAwvalid), .axi_awready_i(wbAwready),
    .axi_wdata_o(wbWdataO), .axi_wstrb_o(wbWstrbO), .axi_wlast_o(wbWlast),
    .axi_wvalid_o(wbWvalid), .axi_wready_i(wbWready), .axi_bid_i(bid),
    .axi_bresp_i(wbBresp), .axi_bvalid_i(wbBvalid), .axi_bready_o(wbBready)
  );

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts every check, reports each mismatch.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request to the chosen instance for exactly one cycle; the
  // engine must be ready, so the request is accepted on that edge.
  task automatic applyStimulus(input bit toWb, input logic [31:0] addr,
                               input logic [127:0] data, input logic [3:0] strb);
    if (toWb) begin
      checkOutput("wb ready before request", wbReady, 1);
      wbAddr = addr; wbWdata = data; wbWstrb = strb; wbValid = 1'b1;
    end else begin
      checkOutput("wt ready before request", wtReady, 1);
      wtAddr = addr; wtWdata = data[31:0]; wtWstrb = strb; wtValid = 1'b1;
    end
    tick();
    wtValid = 1'b0;
    wbValid = 1'b0;
  endtask

  // Run a write-through request to completion and count AW handshakes.
  task automatic runWtToIdle(output int xfers);
    xfers = 0;
    for (int c = 0; c < 40; c++) begin
      if (wtReady) break;
      if (wtAwvalid && wtAwready) xfers++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int xfers;
    reset = 1'b1;
    bid = '0;
    wtValid = 0; wtAddr = '0; wtWdata = '0; wtWstrb = '0; wtErrClr = 0;
    wtAwready = 1; wtWready = 1; wtBvalid = 0; wtBresp = 2'b00;
    wbValid = 0; wbAddr = '0; wbWdata = '0; wbWstrb = '0; wbErrClr = 0;
    wbAwready = 1; wbWready = 1; wbBvalid = 0; wbBresp = 2'b00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    checkOutput("rst wt ready", wtReady, 1);
    checkOutput("rst wt awvalid", wtAwvalid, 0);
    checkOutput("rst wt wvalid", wtWvalid, 0);
    checkOutput("rst wt bready", wtBready, 0);
    checkOutput("rst wt error", wtError, 0);
    checkOutput("rst wb ready", wbReady, 1);
    checkOutput("rst wb wvalid", wbWvalid, 0);

    // An error response while idle is ignored
    wtBvalid = 1; wtBresp = 2'b10; wbBvalid = 1;
    tick(); tick();
    checkOutput("idle bvalid error", wtError, 0);
    checkOutput("idle bvalid ready", wtReady, 1);
    wtBresp = 2'b00;

    // Write-through single beat, upper lane of BE word
    applyStimulus(0, 32'h104, 128'hDEADBEEF, 4'hF);
    checkOutput("wt1 awvalid", wtAwvalid, 1);
    checkOutput("wt1 wvalid", wtWvalid, 1);
    checkOutput("wt1 ready low", wtReady, 0);
    checkOutput("wt1 awaddr", wtAwaddr, 32'h100);
    checkOutput("wt1 wdata", wtWdataO, 64'hDEADBEEF_DEADBEEF);
    checkOutput("wt1 wstrb", wtWstrbO, 8'hF0);
    checkOutput("wt1 wlast", wtWlast, 1);
    checkOutput("wt1 awlen", wtAwlen, 0);
    checkOutput("wt1 awsize", wtAwsize, 3);
    checkOutput("wt1 awburst", wtAwburst, 1);
    checkOutput("wt1 awcache", wtAwcache, 4'b0011);
    checkOutput("wt1 awid/lock/prot/qos", {wtAwid, wtAwlock, wtAwprot, wtAwqos}, 0);
    tick();
    checkOutput("wt1 bready", wtBready, 1);
    checkOutput("wt1 awvalid done", wtAwvalid, 0);
    checkOutput("wt1 wvalid done", wtWvalid, 0);
    tick();
    checkOutput("wt1 ready after 3 cycles", wtReady, 1);

    // Write-through, lower lane, partial strobe
    applyStimulus(0, 32'h208, 128'h12345678, 4'h3);
    checkOutput("wt2 awaddr", wtAwaddr, 32'h208);
    checkOutput("wt2 wdata", wtWdataO, 64'h12345678_12345678);
    checkOutput("wt2 wstrb", wtWstrbO, 8'h03);
    tick(); tick();
    checkOutput("wt2 ready", wtReady, 1);

    // Write-through, unaligned byte address in upper lane
    applyStimulus(0, 32'h10E, 128'hA5A5A5A5, 4'hC);
    checkOutput("wt3 awaddr", wtAwaddr, 32'h108);
    checkOutput("wt3 wstrb", wtWstrbO, 8'hC0);
    tick(); tick();
    checkOutput("wt3 ready", wtReady, 1);

    // AW stalled 4 cycles: W finishes first, RESP waits for AW
    wtAwready = 0;
    applyStimulus(0, 32'h300, 128'hCAFEF00D, 4'hF);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("aw stall %0d awvalid", i), wtAwvalid, 1);
      checkOutput($sformatf("aw stall %0d wvalid", i), wtWvalid, (i == 0));
      checkOutput($sformatf("aw stall %0d bready", i), wtBready, 0);
      tick();
    end
    wtAwready = 1;
    checkOutput("aw stall release awvalid", wtAwvalid, 1);
    tick();
    checkOutput("aw stall resp", wtBready, 1);
    tick();
    checkOutput("aw stall ready", wtReady, 1);

    // SLVERR on every response
    wtBresp = 2'b10;
    applyStimulus(0, 32'h400, 128'h1, 4'hF);
    runWtToIdle(xfers);
    checkOutput("slverr idle", wtReady, 1);
    checkOutput("slverr transfers", xfers, EXP_XFERS);
    checkOutput("slverr error", wtError, 1);
    wtErrClr = 1;
    tick();
    wtErrClr = 0;
    checkOutput("error clear", wtError, 0);

    // DECERR with clear held: set wins over clear
    wtBresp = 2'b11;
    wtErrClr = 1;
    applyStimulus(0, 32'h404, 128'h2, 4'hF);
    runWtToIdle(xfers);
    wtErrClr = 0;
    checkOutput("decerr transfers", xfers, EXP_XFERS);
    checkOutput("decerr set wins", wtError, 1);
    tick();
    checkOutput("decerr sticky", wtError, 1);

    // Next request after an error is accepted normally
    wtBresp = 2'b00;
    applyStimulus(0, 32'h500, 128'h55, 4'h1);
    checkOutput("post err awvalid", wtAwvalid, 1);
    checkOutput("post err wstrb", wtWstrbO, 8'h01);
    tick(); tick();
    checkOutput("post err ready", wtReady, 1);

    // Write-back two-beat burst
    applyStimulus(1, 32'h230, 128'h1111111122222222_3333333344444444, 4'h0);
    checkOutput("wb1 awvalid", wbAwvalid, 1);
    checkOutput("wb1 wvalid", wbWvalid, 1);
    checkOutput("wb1 awaddr", wbAwaddr, 32'h230);
    checkOutput("wb1 awlen", wbAwlen, 1);
    checkOutput("wb1 awsize/burst", {wbAwsize, wbAwburst}, {3'd3, 2'b01});
    checkOutput("wb1 beat0 data", wbWdataO, 64'h3333333344444444);
    checkOutput("wb1 beat0 wstrb", wbWstrbO, 8'hFF);
    checkOutput("wb1 beat0 wlast", wbWlast, 0);
    tick();
    checkOutput("wb1 beat1 awvalid", wbAwvalid, 0);
    checkOutput("wb1 beat1 wvalid", wbWvalid, 1);
    checkOutput("wb1 beat1 data", wbWdataO, 64'h1111111122222222);
    checkOutput("wb1 beat1 wlast", wbWlast, 1);
    checkOutput("wb1 beat1 bready", wbBready, 0);
    tick();
    checkOutput("wb1 resp", wbBready, 1);
    tick();
    checkOutput("wb1 ready", wbReady, 1);

    // Write-back with W stalled one cycle: beat counter holds
    wbWready = 0;
    applyStimulus(1, 32'h23C, 128'hA0A0A0A0A0A0A0A0_B0B0B0B0B0B0B0B0, 4'h0);
    checkOutput("wb2 awaddr line aligned", wbAwaddr, 32'h230);
    tick();
    checkOutput("wb2 stalled data", wbWdataO, 64'hB0B0B0B0B0B0B0B0);
    checkOutput("wb2 stalled wlast", wbWlast, 0);
    wbWready = 1;
    tick();
    checkOutput("wb2 beat1 data", wbWdataO, 64'hA0A0A0A0A0A0A0A0);
    checkOutput("wb2 beat1 wlast", wbWlast, 1);
    tick();
    checkOutput("wb2 resp", wbBready, 1);
    tick();
    checkOutput("wb2 ready", wbReady, 1);

    // Reset during beat 1 of 2 (also clears the pending write-through error)
    applyStimulus(1, 32'h240, 128'hC1C1C1C1C1C1C1C1_D2D2D2D2D2D2D2D2, 4'h0);
    tick();
    checkOutput("rst mid wlast", wbWlast, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst mid wvalid", wbWvalid, 0);
    checkOutput("rst mid awvalid", wbAwvalid, 0);
    checkOutput("rst mid wt error", wtError, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst mid ready", wbReady, 1);
    checkOutput("rst mid bready", wbBready, 0);
    applyStimulus(1, 32'h250, 128'hE3E3E3E3E3E3E3E3_F4F4F4F4F4F4F4F4, 4'h0);
    checkOutput("post rst awaddr", wbAwaddr, 32'h250);
    checkOutput("post rst beat0 data", wbWdataO, 64'hF4F4F4F4F4F4F4F4);
    checkOutput("post rst beat0 wlast", wbWlast, 0);
    tick();
    checkOutput("post rst beat1 data", wbWdataO, 64'hE3E3E3E3E3E3E3E3);
    tick(); tick();
    checkOutput("post rst ready", wbReady, 1);
    checkOutput("wb error clean", wbError, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
